serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor that computes A - B - Bin one bit per clock, LSB first.
- Reuses the existing combinational full_subtractor_using_demux cell as its single-bit datapath, with the borrow held in a flop between cycles.
- Sits directly downstream of that cell: it sequences the cell's inputs and collects its diff/bout outputs into a word-level result with a start/done handshake.
- Intended as the area-minimal word subtractor for control-path arithmetic.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/full_subtractor_using_demux.sv | 26 ++
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encoding and sizing helper for serial_subtractor
// Contents: state_t (ST_IDLE, ST_SHIFT) and clog2(), used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;

  // Bits needed to count 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bus of serial_subtractor
// master: drives start, a_in, b_in, bin_in; observes busy, done, diff_out, bout_out, ovf_out.
// slave : the subtractor side, directions reversed.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             bout_out;
  logic             ovf_out;

  modport master (
    output start, a_in, b_in, bin_in,
    input  busy, done, diff_out, bout_out, ovf_out
  );

  modport slave (
    input  start, a_in, b_in, bin_in,
    output busy, done, diff_out, bout_out, ovf_out
  );

endinterface

// File: rtl/full_subtractor_using_demux.sv
// rtl/full_subtractor_using_demux.sv - one-bit full subtractor built from a 1-to-8 demux
// Ports: a, b, bin (inputs); diff = a ^ b ^ bin, bout = borrow out of a - b - bin.
module full_subtractor_using_demux (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic [2:0] sel;
  logic [7:0] line;

  assign sel = {a, b, bin};

  // Demux a constant 1 onto the minterm line selected by {a, b, bin}.
  always_comb begin
    line      = '0;
    line[sel] = 1'b1;
  end

  // diff is odd parity (minterms 1,2,4,7); borrow when a < b + bin (minterms 1,2,3,7).
  assign diff = line[1] | line[2] | line[4] | line[7];
  assign bout = line[1] | line[2] | line[3] | line[7];

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, one bit per clock
// Ports: clk, rst_n (sync active-low); bus (slave): start/a_in/b_in/bin_in in,
//        busy/done/diff_out/bout_out/ovf_out out, all outputs registered.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             brw_q, brw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_diff;
  logic             cell_bout;

  full_subtractor_using_demux u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (brw_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a_in;
          b_sr_d  = bus.b_in;
          brw_d   = bus.bin_in;
          r_sr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = {cell_diff, r_sr_q[WIDTH-1:1]};
        brw_d  = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // On the MSB cycle the borrow flop holds the borrow into the MSB,
          // so signed overflow is that value XOR the MSB borrow-out.
          diff_d  = {cell_diff, r_sr_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          ovf_d   = brw_q ^ cell_bout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff_out = diff_q;
  assign bus.bout_out = bout_q;
  assign bus.ovf_out  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor against an arithmetic model
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] prev_diff = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  task automatic model(input int a, input int b, input int bin,
                       output int d, output int bo, output int ov);
    int sa, sb, sres;
    d    = (a - b - bin) & 8'hFF;
    bo   = (a < b + bin) ? 1 : 0;
    sa   = (a > 127) ? a - 256 : a;
    sb   = (b > 127) ? b - 256 : b;
    sres = sa - sb - bin;
    ov   = (sres < -128 || sres > 127) ? 1 : 0;
  endtask

  // Drive start with operands at a negedge; returns one cycle later with start low
  // and the operand inputs scrambled so a missed capture would show.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus.start  = 1'b1;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.bin_in = bin;
    @(negedge clk);
    cyc        = 1;
    bus.start  = 1'b0;
    bus.a_in   = 8'($urandom);
    bus.b_in   = 8'($urandom);
    bus.bin_in = 1'($urandom);
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("diff_held", 32'(bus.diff_out), 32'(prev_diff));
  endtask

  // Wait (bounded) for done, optionally throwing random start pulses and operand
  // noise while busy; then compare the result and the latency.
  task automatic wait_done(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic bin, input bit noise);
    int d, bo, ov;
    model(int'(a), int'(b), int'(bin), d, bo, ov);
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (noise && cyc < 9) begin
        bus.start  = 1'($urandom);
        bus.a_in   = 8'($urandom);
        bus.b_in   = 8'($urandom);
        bus.bin_in = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'd9);
    check({tag, "_diff"}, 32'(bus.diff_out), 32'(d));
    check({tag, "_bout"}, 32'(bus.bout_out), 32'(bo));
    check({tag, "_ovf"}, 32'(bus.ovf_out), 32'(ov));
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    prev_diff = 8'(d);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
  } vec_t;

  vec_t dir[8];

  initial begin
    int dones;
    logic [7:0] ra, rb;
    logic       rbin;

    dir[0] = '{8'h5A, 8'h23, 1'b0};
    dir[1] = '{8'h10, 8'h20, 1'b0};
    dir[2] = '{8'h00, 8'h00, 1'b1};
    dir[3] = '{8'h80, 8'h01, 1'b0};
    dir[4] = '{8'h7F, 8'hFF, 1'b0};
    dir[5] = '{8'hFF, 8'hFF, 1'b1};
    dir[6] = '{8'h00, 8'hFF, 1'b1};
    dir[7] = '{8'h7F, 8'h80, 1'b1};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a_in   = 8'h00;
    bus.b_in   = 8'h00;
    bus.bin_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff_out), 32'd0);
    check("rst_bout", 32'(bus.bout_out), 32'd0);
    check("rst_ovf", 32'(bus.ovf_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back to back through the done cycle.
    for (int i = 0; i < 8; i++) begin
      launch(dir[i].a, dir[i].b, dir[i].bin);
      wait_done($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].bin, 1'b0);
    end

    // A second start while busy (sampled at edge k+3) must be ignored.
    launch(8'h05, 8'h03, 1'b0);
    @(negedge clk); cyc++;
    bus.start = 1'b1;
    bus.a_in  = 8'hFF;
    @(negedge clk); cyc++;
    bus.start = 1'b0;
    wait_done("ignored_start", 8'h05, 8'h03, 1'b0, 1'b0);
    // Start asserted during the done cycle is accepted.
    launch(8'h09, 8'h04, 1'b0);
    wait_done("done_cycle_start", 8'h09, 8'h04, 1'b0, 1'b0);

    // Reset in the middle of an operation aborts it without a done.
    launch(8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_diff", 32'(bus.diff_out), 32'd0);
    check("midrst_bout", 32'(bus.bout_out), 32'd0);
    check("midrst_ovf", 32'(bus.ovf_out), 32'd0);
    rst_n     = 1'b1;
    prev_diff = 8'h00;
    dones     = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    launch(8'hC3, 8'h3C, 1'b1);
    wait_done("after_rst", 8'hC3, 8'h3C, 1'b1, 1'b0);

    // Randomized operations with start/operand noise while busy.
    for (int n = 0; n < 1500; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      launch(ra, rb, rbin);
      wait_done("rand", ra, rb, rbin, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
